// File: rtl/adderc_pkg.sv
// Shared helpers for the pipelined carry adder: chunk geometry and
// saturation constants sized up to MAX_WIDTH and sliced by the user.
package adderc_pkg;

   localparam int MAX_WIDTH = 1024;

   typedef logic [MAX_WIDTH-1:0] wide_t;

   function automatic int chunk_width(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   // Chunks past the top of the word collapse to lo == width (an empty stage).
   function automatic int chunk_lo(input int k, input int cw, input int width);
      return (k * cw < width) ? k * cw : width;
   endfunction

   function automatic int chunk_hi(input int k, input int cw, input int width);
      return (((k + 1) * cw < width) ? (k + 1) * cw : width) - 1;
   endfunction

   function automatic wide_t sat_max(input int width);
      wide_t r;
      r = '0;
      for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic wide_t sat_min(input int width);
      wide_t r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/adderc_stage.sv
// One carry-pipeline stage: adds bits [HI:LO] of the skewed operands and
// registers the partial result, carry, operands and valid together.
module adderc_stage #(
   parameter int WIDTH = 16,
   parameter int LO    = 0,
   parameter int HI    = 7
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             enable,
   input  logic             vld,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] part,
   input  logic             ci,
   output logic             vld_q,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] part_q,
   output logic             co_q
);

   logic [WIDTH-1:0] placed;
   logic             carry_next;

   generate
      if (LO < WIDTH) begin : g_add
         localparam int CW = HI - LO + 1;
         logic [CW:0] chunk_sum;
         always_comb begin
            chunk_sum       = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]} + {{CW{1'b0}}, ci};
            placed          = '0;
            placed[HI:LO]   = chunk_sum[CW-1:0];
            carry_next      = chunk_sum[CW];
         end
      end else begin : g_pass
         // Trailing empty stage: the word is already complete, only delay it.
         always_comb begin
            placed     = '0;
            carry_next = ci;
         end
      end
   endgenerate

   // Chunk bits of part are always zero on entry, so OR merges the new chunk.
   always_ff @(posedge clk) begin
      if (srst) begin
         vld_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         part_q <= '0;
         co_q   <= 1'b0;
      end else if (enable) begin
         vld_q  <= vld;
         a_q    <= a;
         b_q    <= b;
         part_q <= part | placed;
         co_q   <= carry_next;
      end
   end

endmodule

// File: rtl/adderc_pipe.sv
// Pipelined add/subtract with carry in/out, signed overflow and optional
// saturation; the carry chain is split over STAGES registered chunks.
module adderc_pipe
   import adderc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int STAGES   = 2,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             enable,
   input  logic             in_valid,
   input  logic             sub_nadd,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   localparam int    CW        = chunk_width(WIDTH, STAGES);
   localparam wide_t SAT_MAX_W = sat_max(WIDTH);
   localparam wide_t SAT_MIN_W = sat_min(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_W[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_W[WIDTH-1:0];

   // Index k is the input of stage k; index STAGES is the final register set.
   logic [WIDTH-1:0] opa  [0:STAGES];
   logic [WIDTH-1:0] opb  [0:STAGES];
   logic [WIDTH-1:0] part [0:STAGES];
   logic             carry[0:STAGES];
   logic             vld  [0:STAGES];

   assign opa[0]   = a;
   assign opb[0]   = sub_nadd ? ~b : b;
   assign part[0]  = '0;
   assign carry[0] = cin;
   assign vld[0]   = in_valid;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         adderc_stage #(
            .WIDTH (WIDTH),
            .LO    (chunk_lo(k, CW, WIDTH)),
            .HI    (chunk_hi(k, CW, WIDTH))
         ) u_stage (
            .clk    (clk),
            .srst   (srst),
            .enable (enable),
            .vld    (vld[k]),
            .a      (opa[k]),
            .b      (opb[k]),
            .part   (part[k]),
            .ci     (carry[k]),
            .vld_q  (vld[k+1]),
            .a_q    (opa[k+1]),
            .b_q    (opb[k+1]),
            .part_q (part[k+1]),
            .co_q   (carry[k+1])
         );
      end
   endgenerate

   logic [WIDTH-1:0] raw;
   logic             a_msb;
   logic             b_msb;

   assign raw   = part[STAGES];
   assign a_msb = opa[STAGES][WIDTH-1];
   assign b_msb = opb[STAGES][WIDTH-1];

   // ovf and cout always describe the unsaturated sum.
   assign ovf       = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
   assign cout      = carry[STAGES];
   assign out_valid = vld[STAGES];
   assign out       = ((SATURATE != 0) && ovf) ? (a_msb ? SAT_MIN : SAT_MAX) : raw;

endmodule
